shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, data width in bits; the shift-count width is log2(WIDTH) (5 at default).
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous assert, active-low, synchronous deassert assumed by integrator.
REQ-004 Port: start  in  1  request pulse; sampled only in IDLE.
REQ-005 Port: A  in  WIDTH  operand, captured on accepted start.
REQ-006 Port: shamt  in  5  shift count 0..31, captured on accepted start.
REQ-007 Port: dir  in  1  0 = right, 1 = left, captured on accepted start.
REQ-008 Port: sign  in  1  1 = arithmetic (right only; ignored for left), captured on accepted start.
REQ-009 Port: result  out  WIDTH  shifted value, valid when done=1, held until next accepted start.
REQ-010 Port: busy  out  1  high from the cycle after an accepted start through the final SHIFT cycle.
REQ-011 Port: done  out  1  one-cycle completion pulse.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; encoding is free.
REQ-013 IDLE: start=1 -> capture A into working register, shamt into remaining counter, dir/sign into op flags; go to SHIFT if shamt!=0, else DONE.
REQ-014 SHIFT: each cycle shift the working register by exactly 1 bit and decrement remaining; when remaining reaches 0 after this cycle's decrement, go to DONE.
REQ-015 Right logical fill = 0; right arithmetic fill = current MSB of working register; left fill = 0 at LSB.
REQ-016 DONE: done=1, busy=0, result=working register; unconditionally return to IDLE next cycle.
REQ-017 Latency: start accepted at cycle T -> done at cycle T+shamt+1 (shamt=0 -> T+1).
REQ-018 start while busy or in DONE is ignored; no queueing, no error flag.
REQ-019 Operand/control inputs changing after capture do not affect the operation in progress.
REQ-020 result reflects the working register at all times; it is stable from DONE until the next accepted start.
REQ-021 start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted (back-to-back throughput = shamt+2 cycles).

Reset
REQ-022 rst_n=0 immediately forces state=IDLE, working register=0, remaining=0, op flags=0, busy=0, done=0, result=0.
REQ-023 Reset during SHIFT aborts the operation with no done pulse; first start after release is accepted normally.

Configuration
REQ-024 Macro SHIFT_SEQ_FASTPATH_EN defined: in SHIFT, when remaining>=4, shift by 4 bits and subtract 4 in one cycle, else by 1; right-arithmetic fill replicates the MSB across all vacated bits.
REQ-025 With the macro defined, latency = floor(shamt/4) + (shamt mod 4) + 1 cycles after acceptance; all other rules unchanged.
REQ-026 Macro undefined: 1 bit per cycle only; no 4-bit shift logic present.

Verification
REQ-027 Reset, then start with A=0x80000000, shamt=4, dir=0, sign=1 -> done at T+5, result=0xF8000000 (fast path: T+2).
REQ-028 A=0x80000000, shamt=31, dir=0, sign=0 -> done at T+32, result=0x00000001; busy high for 31 cycles.
REQ-029 A=0x12345678, shamt=0, any dir -> done at T+1, result=0x12345678, busy never high.
REQ-030 A=0x0000000F, shamt=8, dir=1; second start pulsed at T+3 with A=0 -> second start ignored, result=0x00000F00.
REQ-031 Start shamt=20, assert rst_n=0 at T+5 -> result=0, busy=0 immediately, no done; new start after release with A=0xFFFFFFFF, shamt=1, dir=0, sign=1 -> result=0xFFFFFFFF.

Source files
------------

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// shift_sequencer_if : request/response bundle for shift_sequencer
// Revision 1.0 - initial release
// ============================================================================
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [SW-1:0]    shamt;
  logic             dir;
  logic             sign;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (output start, A, shamt, dir, sign, input result, busy, done);
  modport slave  (input start, A, shamt, dir, sign, output result, busy, done);
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// shift_sequencer : multi-cycle shifter, one bit per cycle (4 with SHIFT_SEQ_FASTPATH_EN)
// Revision 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  shift_sequencer_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_work;
  logic [SW-1:0]    r_rem;
  logic             r_dir;
  logic             r_sign;

  logic [WIDTH-1:0] w_work_nxt;
  logic [SW-1:0]    w_rem_nxt;
  logic             w_fill;

  // Arithmetic fill tracks the live MSB, so it equals the original sign bit throughout.
  assign w_fill = r_sign & r_work[WIDTH-1];

`ifdef SHIFT_SEQ_FASTPATH_EN
  always_comb begin
    w_rem_nxt  = r_rem - SW'(1);
    w_work_nxt = r_dir ? {r_work[WIDTH-2:0], 1'b0} : {w_fill, r_work[WIDTH-1:1]};
    if (r_rem >= SW'(4)) begin
      w_rem_nxt  = r_rem - SW'(4);
      w_work_nxt = r_dir ? {r_work[WIDTH-5:0], 4'b0000}
                         : {{4{w_fill}}, r_work[WIDTH-1:4]};
    end
  end
`else
  always_comb begin
    w_rem_nxt  = r_rem - SW'(1);
    w_work_nxt = r_dir ? {r_work[WIDTH-2:0], 1'b0} : {w_fill, r_work[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_sign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_work  <= bus.A;
            r_rem   <= bus.shamt;
            r_dir   <= bus.dir;
            r_sign  <= bus.sign;
            r_state <= (bus.shamt != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_work <= w_work_nxt;
          r_rem  <= w_rem_nxt;
          if (w_rem_nxt == '0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = r_work;
  assign bus.busy   = (r_state == S_SHIFT);
  assign bus.done   = (r_state == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// tb_shift_sequencer : directed stimulus with queue-based result scoreboard
// Revision 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;
  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] res;
    int          edge_n;
  } exp_t;
  exp_t sb_q[$];

  shift_sequencer_if #(.WIDTH(WIDTH)) bus ();

  shift_sequencer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int sh);
`ifdef SHIFT_SEQ_FASTPATH_EN
    return sh / 4 + sh % 4;
`else
    return sh;
`endif
  endfunction

  // Completion monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got result 0x%08h with no request outstanding", bus.result);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.result, e.res);
        check("done_cycle", cyc, e.edge_n);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input int sh, input logic d, input logic s,
                        input logic [31:0] exp_res, input int extra_at, input bit poke_done,
                        input string name);
    int   busy_n;
    int   lat;
    bit   seen;
    exp_t e;
    busy_n = 0;
    seen   = 1'b0;
    lat    = lat_of(sh);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.shamt = sh[4:0];
    bus.dir   = d;
    bus.sign  = s;
    e.res     = exp_res;
    e.edge_n  = cyc + 1 + lat;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.shamt = 5'd31 ^ sh[4:0];
    bus.dir   = ~d;
    bus.sign  = ~s;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_n++;
        if (i == extra_at) begin
          bus.start = 1'b1;
          bus.A     = '0;
        end
        if (i == extra_at + 1) bus.start = 1'b0;
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 100 cycles, required done", name);
    end
    check({name, "_busy_cycles"}, busy_n, lat);
    if (seen && poke_done) begin
      bus.start = 1'b1;
      bus.A     = 32'hDEADBEEF;
      bus.shamt = 5'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.shamt = '0;
    bus.dir   = 1'b0;
    bus.sign  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.result, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_done", {31'b0, bus.done}, 32'h0);
    rst_n = 1'b1;

    run_op(32'h80000000,  4, 1'b0, 1'b1, 32'hF8000000, -1, 1'b0, "asr4");
    run_op(32'h80000000, 31, 1'b0, 1'b0, 32'h00000001, -1, 1'b0, "lsr31");
    run_op(32'h12345678,  0, 1'b0, 1'b0, 32'h12345678, -1, 1'b1, "zero_r");
    run_op(32'h12345678,  0, 1'b1, 1'b1, 32'h12345678, -1, 1'b0, "zero_l");
    run_op(32'h0000000F,  8, 1'b1, 1'b0, 32'h00000F00,  2, 1'b0, "lsl8_ign");
    run_op(32'h80000001,  1, 1'b1, 1'b1, 32'h00000002, -1, 1'b0, "lsl_signed");
    run_op(32'h7FFFFFFF,  3, 1'b0, 1'b1, 32'h0FFFFFFF, -1, 1'b0, "asr_pos");
    run_op(32'hF0000000,  5, 1'b0, 1'b0, 32'h07800000, -1, 1'b1, "lsr5");
    run_op(32'h00000001, 31, 1'b1, 1'b0, 32'h80000000, -1, 1'b0, "lsl31");
    run_op(32'h80000000,  7, 1'b0, 1'b1, 32'hFF000000, -1, 1'b0, "asr7");
    repeat (4) @(negedge clk);
    check("result_held", bus.result, 32'hFF000000);

    // Abort an operation mid-flight with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'hFFFFFFFF;
    bus.shamt = 5'd20;
    bus.dir   = 1'b0;
    bus.sign  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", {31'b0, bus.busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", bus.result, 32'h0);
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_done", {31'b0, bus.done}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    run_op(32'hFFFFFFFF,  1, 1'b0, 1'b1, 32'hFFFFFFFF, -1, 1'b0, "post_reset");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
